// File: rtl/gl_pixel_writer_pkg.sv
// ---------------------------------------------------------------------------
// gl_pixel_writer_pkg
// Shared definitions for the rasterizer pixel writer (the "gl_defines" of the
// pixel path): pixel word field offsets, default framebuffer geometry and the
// writer FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package gl_pixel_writer_pkg;

  // Pixel word layout: {x[31:0], y[31:0], colour[31:0]}
  localparam int PIX_W    = 96;
  localparam int PIX_X_HI = 95;
  localparam int PIX_X_LO = 64;
  localparam int PIX_Y_HI = 63;
  localparam int PIX_Y_LO = 32;
  localparam int PIX_C_HI = 31;
  localparam int PIX_C_LO = 0;

  localparam int DEF_FB_WIDTH  = 640;
  localparam int DEF_FB_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_CLR_WAIT = 2'd1,
    ST_CLEAR    = 2'd2
  } wr_state_e;

endpackage

// File: rtl/gl_pixel_fifo.sv
// ---------------------------------------------------------------------------
// gl_pixel_fifo
// Single-clock FIFO with wrapping pointers and an occupancy count.
// A push while full is dropped; a pop while empty is ignored.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   push_i, wdata_i write request and data
//   pop_i, rdata_o  read request; rdata_o always shows the head entry
//   full_o, empty_o occupancy flags, derived from the registered count
//   count_o         number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module gl_pixel_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of 2, so pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gl_pixel_writer.sv
// ---------------------------------------------------------------------------
// gl_pixel_writer
// Consumer end of the rasterizer pixel stream. Buffers {x,y,colour} words,
// clips them against the framebuffer, and issues linear-address writes
// (addr = y*FB_WIDTH + x). Also fills the whole framebuffer with a colour on
// clear_req. Pixels arriving during a clear are buffered and written after it.
// Optional build macro: GL_PIXEL_STATS_EN adds stat_written/stat_clipped.
// Ports:
//   clk, reset                  raster clock, synchronous active-low reset
//   wr_data, wr_en, full        pixel input; accepted when wr_en && !full
//   clear_req, clear_color      one-cycle clear request and fill colour
//   busy, clear_done            activity flag, one-cycle clear completion
//   fb_addr, fb_data, fb_we     framebuffer write, held until fb_ready
//   fb_ready                    memory accepts when fb_we && fb_ready
//   stat_written, stat_clipped  (GL_PIXEL_STATS_EN only) saturating counters
// ---------------------------------------------------------------------------
module gl_pixel_writer
  import gl_pixel_writer_pkg::*;
#(
  parameter int FB_WIDTH  = DEF_FB_WIDTH,
  parameter int FB_HEIGHT = DEF_FB_HEIGHT,
  parameter int ADDR_W    = 19,
  parameter int DEPTH     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_en,
  output logic              full,
  input  logic              clear_req,
  input  logic [31:0]       clear_color,
  output logic              busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [31:0]       fb_data,
  output logic              fb_we,
  input  logic              fb_ready
`ifdef GL_PIXEL_STATS_EN
  ,
  output logic [31:0]       stat_written,
  output logic [31:0]       stat_clipped
`endif
);

  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  // ---- input FIFO ----------------------------------------------------------
  logic [PIX_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             pop;

  gl_pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // The head is only consumed once the FIFO has held data across an edge;
  // this models a registered FIFO read and sets the push-to-write latency.
  logic head_ready_q;

  always_ff @(posedge clk) begin
    if (!reset) head_ready_q <= 1'b0;
    else        head_ready_q <= (count != '0);
  end

  // ---- address / clip ------------------------------------------------------
  logic [31:0] px, py, pc, lin;
  logic        clip;

  assign px   = head[PIX_X_HI:PIX_X_LO];
  assign py   = head[PIX_Y_HI:PIX_Y_LO];
  assign pc   = head[PIX_C_HI:PIX_C_LO];
  assign clip = (px >= 32'(FB_WIDTH)) || (py >= 32'(FB_HEIGHT));
  assign lin  = py * 32'(FB_WIDTH) + px;

  // ---- FSM state -----------------------------------------------------------
  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]       clr_color_q, clr_color_d;
  logic              done_q, done_d;

  // ---- output register -----------------------------------------------------
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              out_free;

  assign out_free = !we_q || fb_ready;
  // Clipped pixels are discarded without needing the output stage.
  assign pop = (state_q == ST_RUN) && head_ready_q && !fifo_empty &&
               (clip || out_free);

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (out_free) begin
      we_q <= pop && !clip;
      if (pop && !clip) begin
        addr_q <= lin[ADDR_W-1:0];
        data_q <= pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      done_q      <= done_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    done_d      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (clear_req) begin
          state_d     = ST_CLR_WAIT;
          clr_color_d = clear_color;
        end
      end
      ST_CLR_WAIT: begin
        if (!we_q) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (fb_ready) begin
          if (clr_cnt_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // The output register is idle throughout CLEAR, so the clear stream is
  // muxed straight onto the memory port.
  assign fb_we      = (state_q == ST_CLEAR) || we_q;
  assign fb_addr    = (state_q == ST_CLEAR) ? clr_cnt_q : addr_q;
  assign fb_data    = (state_q == ST_CLEAR) ? clr_color_q : data_q;
  assign clear_done = done_q;
  assign busy       = !fifo_empty || fb_we || (state_q != ST_RUN);

`ifdef GL_PIXEL_STATS_EN
  logic [31:0] written_q, clipped_q;

  // Zeroed on the edge that raises clear_done; no pixel traffic happens in
  // CLEAR, so nothing is lost at that edge.
  always_ff @(posedge clk) begin
    if (!reset || done_d) begin
      written_q <= '0;
      clipped_q <= '0;
    end else begin
      if (we_q && fb_ready && written_q != '1) written_q <= written_q + 1'b1;
      if (pop && clip && clipped_q != '1)      clipped_q <= clipped_q + 1'b1;
    end
  end

  assign stat_written = written_q;
  assign stat_clipped = clipped_q;
`endif

endmodule

// File: tb/tb_gl_pixel_writer.sv
// ---------------------------------------------------------------------------
// tb_gl_pixel_writer
// Self-checking bench for gl_pixel_writer on a reduced 48x32 framebuffer.
// A reference model turns each pushed pixel into its expected write
// (y*W+x, colour) or a clip; a monitor logs every accepted memory write.
// ---------------------------------------------------------------------------
module tb_gl_pixel_writer;

  localparam int W     = 48;
  localparam int H     = 32;
  localparam int AW    = 19;
  localparam int DEPTH = 8;
  localparam int NPIX  = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic [95:0]   wr_data;
  logic          wr_en;
  logic          full;
  logic          clear_req;
  logic [31:0]   clear_color;
  logic          busy;
  logic          clear_done;
  logic [AW-1:0] fb_addr;
  logic [31:0]   fb_data;
  logic          fb_we;
  logic          fb_ready;
`ifdef GL_PIXEL_STATS_EN
  logic [31:0]   stat_written;
  logic [31:0]   stat_clipped;
`endif

  always #5 clk = ~clk;

  gl_pixel_writer #(
    .FB_WIDTH  (W),
    .FB_HEIGHT (H),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .busy        (busy),
    .clear_done  (clear_done),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .fb_ready    (fb_ready)
`ifdef GL_PIXEL_STATS_EN
    ,
    .stat_written (stat_written),
    .stat_clipped (stat_clipped)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [50:0] exp_q[$];
  logic [50:0] got_q[$];
  logic [50:0] hold_q[$];
  int          wr_cyc_q[$];
  logic          stall_prev = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_we_held", 64'(fb_we), 64'(1));
        check("stall_addr_data_stable", 64'({fb_addr, fb_data}), 64'({prev_addr, prev_data}));
      end
      if (fb_we && fb_ready) begin
        got_q.push_back({fb_addr, fb_data});
        wr_cyc_q.push_back(cyc);
      end
      if (clear_done) done_cnt++;
      stall_prev = fb_we && !fb_ready;
      prev_addr  = fb_addr;
      prev_data  = fb_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) fb_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference model: where a pixel lands in the framebuffer, if anywhere.
  function automatic bit in_fb(input int unsigned x, input int unsigned y);
    return (x < W) && (y < H);
  endfunction

  function automatic logic [50:0] model_write(input int unsigned x, input int unsigned y,
                                              input logic [31:0] c);
    int unsigned a;
    a = y * W + x;
    return {a[AW-1:0], c};
  endfunction

  // dest: 0 = expected now, 1 = expected after a clear, 2 = will be abandoned
  task automatic push_pix(input int unsigned x, input int unsigned y, input logic [31:0] c,
                          input bit exp_accept, input int dest);
    wr_data = {x, y, c};
    wr_en   = 1'b1;
    check("full_before_push", 64'(full), 64'(!exp_accept));
    tick();
    wr_en = 1'b0;
    if (exp_accept && in_fb(x, y)) begin
      if (dest == 0)      exp_q.push_back(model_write(x, y, c));
      else if (dest == 1) hold_q.push_back(model_write(x, y, c));
    end
  endtask

  task automatic drain_compare(input string tag, input bit chk_burst);
    int n = 0;
    while ((busy !== 1'b0 || got_q.size() < exp_q.size()) && n < 5000) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(n < 5000), 64'(1));
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    if (chk_burst && wr_cyc_q.size() > 0)
      check({tag, "_no_bubbles"}, 64'(wr_cyc_q[$] - wr_cyc_q[0]), 64'(wr_cyc_q.size() - 1));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    wr_cyc_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    clear_req   = 1'b0;
    clear_color = '0;
    fb_ready    = 1'b1;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_full",       64'(full),       64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_fb_we",      64'(fb_we),      64'(0));
    check("rst_fb_addr",    64'(fb_addr),    64'(0));
    check("rst_fb_data",    64'(fb_data),    64'(0));
    check("rst_clear_done", 64'(clear_done), 64'(0));
    reset = 1'b1;
    tick();

    // ---- single pixel latency: pushed at edge N, visible after N+2 ----
    push_pix(3, 2, 32'h00FF_0000, 1'b1, 0);
    check("lat_we_n0", 64'(fb_we), 64'(0));
    tick();
    check("lat_we_n1", 64'(fb_we), 64'(0));
    tick();
    check("lat_we_n2", 64'(fb_we), 64'(1));
    check("lat_addr",  64'(fb_addr), 64'(2 * W + 3));
    check("lat_data",  64'(fb_data), 64'(32'h00FF_0000));
    drain_compare("lat", 1'b0);
    check("lat_busy_idle", 64'(busy), 64'(0));

    // ---- clipping at both edges, plus the last in-range pixel ----
    push_pix(W, 0, 32'h0000_00AA, 1'b1, 0);
    push_pix(0, H, 32'h0000_00BB, 1'b1, 0);
    push_pix(W - 1, H - 1, 32'h00C0_FFEE, 1'b1, 0);
    drain_compare("clip", 1'b0);
`ifdef GL_PIXEL_STATS_EN
    check("stat_clipped_2", 64'(stat_clipped), 64'(2));
    check("stat_written_2", 64'(stat_written), 64'(2));
`endif

    // ---- back-pressure: 8 buffered + 1 in the output stage, 10th dropped ----
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      push_pix($urandom_range(0, W - 1), $urandom_range(0, H - 1),
               $urandom & 32'h00FF_FFFF, i < 9, 0);
    repeat (5) tick();
    check("stall_full_held", 64'(full), 64'(1));
    check("stall_no_accepts", 64'(got_q.size()), 64'(0));
    fb_ready = 1'b1;
    drain_compare("stall", 1'b0);

    // ---- streaming: one push per cycle, no bubbles, never full ----
    for (int i = 0; i < 100; i++)
      push_pix($urandom_range(0, W - 1), $urandom_range(0, H - 1),
               $urandom & 32'h00FF_FFFF, 1'b1, 0);
    drain_compare("stream", 1'b1);

    // ---- random batches with random clipping and random fb_ready ----
    rand_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++)
        push_pix($urandom_range(0, W + 7), $urandom_range(0, H + 7),
                 $urandom & 32'h00FF_FFFF, 1'b1, 0);
      drain_compare($sformatf("rand%0d", b), 1'b0);
    end
    rand_ready = 1'b0;
    fb_ready   = 1'b1;

    // ---- clear with pixels pending and pixels arriving during the clear ----
    done_cnt = 0;
    fb_ready = 1'b0;
    push_pix(1, 1, 32'h0000_0011, 1'b1, 0);
    push_pix(2, 2, 32'h0000_0022, 1'b1, 1);
    push_pix(3, 3, 32'h0000_0033, 1'b1, 1);
    repeat (4) tick();
    clear_color = 32'h0012_3456;
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
    clear_color = 32'h00AB_CDEF;
    check("clr_busy", 64'(busy), 64'(1));
    fb_ready = 1'b1;
    push_pix(4, 4, 32'h0000_0044, 1'b1, 1);
    push_pix(5, 5, 32'h0000_0055, 1'b1, 1);
    repeat (20) tick();
    clear_req = 1'b1;  // must be ignored outside RUN
    tick();
    clear_req = 1'b0;
    for (int a = 0; a < NPIX; a++) exp_q.push_back({a[AW-1:0], 32'h0012_3456});
    while (hold_q.size() > 0) exp_q.push_back(hold_q.pop_front());
    drain_compare("clear", 1'b0);
    check("clear_done_once", 64'(done_cnt), 64'(1));
`ifdef GL_PIXEL_STATS_EN
    check("stat_written_post_clear", 64'(stat_written), 64'(4));
    check("stat_clipped_post_clear", 64'(stat_clipped), 64'(0));
`endif

    // ---- reset in the middle of a clear ----
    clear_color = 32'h0000_0F0F;
    clear_req   = 1'b1;
    tick();
    clear_req = 1'b0;
    push_pix(6, 6, 32'h0000_0066, 1'b1, 2);
    push_pix(7, 7, 32'h0000_0077, 1'b1, 2);
    n = 0;
    while (!(fb_we === 1'b1 && fb_addr === AW'(1000)) && n < 3000) begin
      tick();
      n++;
    end
    check("midrst_reached_1000", 64'(n < 3000), 64'(1));
    reset = 1'b0;
    tick();
    check("midrst_fb_we", 64'(fb_we), 64'(0));
    check("midrst_busy",  64'(busy),  64'(0));
    check("midrst_full",  64'(full),  64'(0));
    reset = 1'b1;
    got_q.delete();
    exp_q.delete();
    wr_cyc_q.delete();
    tick();
    push_pix(9, 10, 32'h00DE_ADBE, 1'b1, 0);
    drain_compare("post_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gl_pixel_writer.md
Name: gl_pixel_writer

Overview:
Consumer end of the rasterizer pixel stream: accepts {x, y, colour} pixel words on the raster clock, buffers them, clips against the framebuffer, and issues linear-address writes to the framebuffer memory port.
Also performs a framebuffer clear (fill with a colour) on request.
Sits between gl_rasterizer (wr_data/wr_en/full) and the framebuffer BRAM/PLB write port.

Parameters:
FB_WIDTH, 640, framebuffer width in pixels
FB_HEIGHT, 480, framebuffer height in pixels
ADDR_W, 19, framebuffer word-address width (must hold FB_WIDTH*FB_HEIGHT-1)
DEPTH, 8, input pixel FIFO depth (power of 2, >=4)

Ports:
clk  in  1  raster clock (clk2 domain)
reset  in  1  synchronous, active-low reset
wr_data  in  96  pixel: [95:64] x (unsigned int), [63:32] y (unsigned int), [31:0] colour {8'h00,R,G,B}
wr_en  in  1  pixel valid; accepted when wr_en && !full
full  out  1  FIFO cannot accept this cycle
clear_req  in  1  one-cycle request to fill framebuffer with clear_color
clear_color  in  32  fill colour, sampled on accepted clear_req
busy  out  1  FIFO non-empty, write pending, or clear in progress
clear_done  out  1  one-cycle pulse when clear completes
fb_addr  out  ADDR_W  framebuffer word address
fb_data  out  32  framebuffer write data
fb_we  out  1  write valid; held with addr/data until fb_ready
fb_ready  in  1  memory accepts write when fb_we && fb_ready

Behaviour:
- Reset (reset==0 at clk edge): FIFO emptied, state RUN, all outputs 0 (full=0, busy=0, fb_we=0, fb_addr=0, fb_data=0, clear_done=0). Mid-operation reset abandons pending writes and any clear.
- Input FIFO: DEPTH entries, wrapping pointers plus count. full = (count==DEPTH). wr_en while full: pixel dropped, no state change. Simultaneous push and pop at full: the pop frees the slot, but full is registered from count, so that push is still refused.
- Output stage: one register holding fb_addr/fb_data/fb_we. It loads when empty or being consumed (fb_we && fb_ready) in the same cycle, giving one write per cycle at full throughput.
- Address: fb_addr = y*FB_WIDTH + x, truncated to ADDR_W. Constant-multiplier arithmetic is done in 32 bits before truncation.
- Clipping: x >= FB_WIDTH or y >= FB_HEIGHT means the pixel is popped and discarded, with no fb_we.
- Latency: a pixel pushed at edge N yields fb_we=1 in the cycle after edge N+2, provided fb_ready was high and the FIFO was empty.
- fb_we, once asserted, holds fb_addr/fb_data stable until fb_ready is sampled high.
- FSM:
  - RUN: drain FIFO. clear_req -> CLR_WAIT; clear_color is latched.
  - CLR_WAIT: stop popping; wait until the output stage is idle, then go to CLEAR with the address counter at 0.
  - CLEAR: fb_we=1, fb_addr=counter, fb_data=latched colour. Counter increments on each fb_ready. After address FB_WIDTH*FB_HEIGHT-1 is accepted: clear_done=1 for one cycle, then -> RUN.
- clear_req outside RUN is ignored.
- During CLR_WAIT/CLEAR the FIFO still accepts pixels until full. They are written after the clear, never lost.
- busy = (count!=0) || fb_we || (state!=RUN).

Optional Feature:
GL_PIXEL_STATS_EN:
- Defined: adds outputs stat_written[31:0] (pixel writes accepted by memory, excluding clear writes) and stat_clipped[31:0] (pixels discarded by clipping). Both reset to 0, saturate at 32'hFFFFFFFF, and are cleared when clear_done fires.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared gl_defines: pixel field offsets (PIX_X_HI/LO, PIX_Y_HI/LO, PIX_C_HI/LO), FSM state encodings (RUN, CLR_WAIT, CLEAR), default FB_WIDTH/FB_HEIGHT.
- Sub-module: gl_pixel_fifo, a parameterised single-clock FIFO (width 96, DEPTH) with full/empty/count. The remainder, covering address, clip, FSM and output register, stays in gl_pixel_writer.

Test Plan:
- Reset, then push pixel x=3, y=2, colour 32'h00FF0000 with fb_ready=1 -> one fb_we with fb_addr=1283 and fb_data=32'h00FF0000, 3 cycles after the push; busy returns to 0.
- Push x=640, y=0 and x=0, y=480 -> no fb_we; stat_clipped=2 with GL_PIXEL_STATS_EN.
- Hold fb_ready=0 and push 9 pixels -> full=1 after 8 are buffered plus 1 in the output register; the 10th push is dropped. Release fb_ready -> exactly 9 writes, in order, with addr/data stable while stalled.
- clear_req with clear_color=32'h00123456 while pixels are pending -> pending output write completes first, then 307200 writes to addresses 0..307199, clear_done pulses once, then the buffered pixels are written.
- Assert reset low mid-clear at address 1000 -> next cycle fb_we=0, busy=0, full=0; a subsequent pixel writes normally.
- Push every cycle for 100 pixels with fb_ready=1 -> 100 writes with no bubbles after the initial latency, and full is never asserted.
